// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman node store and the pickers that scan it.
package huff_pkg;

    localparam int NODE_W = 36;
    localparam int IDX_W  = 8;

    // An all-ones frame marks an unused store unit.
    localparam logic [NODE_W-1:0] EMPTY_NODE = {NODE_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CLEAN = 2'd2,
        DONE  = 2'd3
    } sel_state_t;

endpackage

// File: rtl/node_cmp.sv
// Candidate-vs-best compare: take the candidate when it is valid and strictly smaller.
module node_cmp #(
    parameter int NODE_W = huff_pkg::NODE_W
) (
    input  logic [NODE_W-1:0] cand,
    input  logic [NODE_W-1:0] best,
    output logic              take
);

    // Strict less-than keeps the earlier (lower index) node on ties.
    assign take = (cand != {NODE_W{1'b1}}) && (cand < best);

endmodule

// File: rtl/node_min_select.sv
// Sequentially scans all node store units and picks the smallest valid frame.
// state | meaning
// IDLE  | waiting for start
// SCAN  | one unit compared per cycle, ascending index
// CLEAN | strobe clean_en for the picked unit (if any)
// DONE  | present result with res_valid for one cycle
module node_min_select
    import huff_pkg::*;
#(
    parameter int NUM_UNITS = 16,
    parameter int NODE_W    = huff_pkg::NODE_W
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic [NODE_W*NUM_UNITS-1:0] nodes_in,
    input  logic                        start,
    output logic                        busy,
    output logic [IDX_W-1:0]            clean,
    output logic                        clean_en,
    output logic [NODE_W-1:0]           min_node,
    output logic [IDX_W-1:0]            min_idx,
    output logic                        min_empty,
    output logic                        res_valid
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);

    sel_state_t        state_q, state_d;
    logic [IDX_W-1:0]  scan_idx_q;
    logic [NODE_W-1:0] best_q;
    logic [IDX_W-1:0]  best_idx_q;
    logic              found_q;
    logic [NODE_W-1:0] cur_node;
    logic              take;

    // Mux driven only by the registered scan index, so each unit is sampled exactly once.
    always_comb begin
        cur_node = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (scan_idx_q == IDX_W'(i)) begin
                cur_node = nodes_in[NODE_W*i +: NODE_W];
            end
        end
    end

    node_cmp #(.NODE_W(NODE_W)) u_cmp (
        .cand (cur_node),
        .best (best_q),
        .take (take)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (scan_idx_q == LAST_IDX) state_d = CLEAN;
            CLEAN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            scan_idx_q <= '0;
            best_q     <= '1;
            best_idx_q <= '0;
            found_q    <= 1'b0;
            min_node   <= '0;
            min_idx    <= '0;
            min_empty  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        scan_idx_q <= '0;
                        best_q     <= '1;
                        best_idx_q <= '0;
                        found_q    <= 1'b0;
                    end
                end
                SCAN: begin
                    if (take) begin
                        best_q     <= cur_node;
                        best_idx_q <= scan_idx_q;
                        found_q    <= 1'b1;
                    end
                    if (scan_idx_q != LAST_IDX) begin
                        scan_idx_q <= scan_idx_q + 1'b1;
                    end
                end
                CLEAN: begin
                    min_node  <= found_q ? best_q : '1;
                    min_idx   <= found_q ? best_idx_q : '0;
                    min_empty <= !found_q;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign clean_en  = (state_q == CLEAN) && found_q;
    assign clean     = clean_en ? best_idx_q : '0;
    assign res_valid = (state_q == DONE);

endmodule

// File: tb/tb_node_min_select.sv
// Directed bench for node_min_select with four store units.
module tb_node_min_select;

    localparam int N  = 4;
    localparam int NW = 36;
    localparam logic [NW-1:0] ONES = {NW{1'b1}};

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic [NW*N-1:0]   nodes_in = '1;
    logic              start = 1'b0;
    logic              busy;
    logic [7:0]        clean;
    logic              clean_en;
    logic [NW-1:0]     min_node;
    logic [7:0]        min_idx;
    logic              min_empty;
    logic              res_valid;

    int n_checks = 0;
    int n_errors = 0;

    int            n_clean, n_res, clean_cyc, res_cyc, clean_val;
    logic          busy_ok, overlap;
    logic [NW-1:0] r_node;
    logic [7:0]    r_idx;
    logic          r_empty;

    always #5 clk = ~clk;

    node_min_select #(.NUM_UNITS(N), .NODE_W(NW)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .nodes_in  (nodes_in),
        .start     (start),
        .busy      (busy),
        .clean     (clean),
        .clean_en  (clean_en),
        .min_node  (min_node),
        .min_idx   (min_idx),
        .min_empty (min_empty),
        .res_valid (res_valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start is high in cycle k; loop index c is cycle k+c.
    task automatic run_pick(input logic repulse, input logic do_change, input logic [NW-1:0] new_u0);
        n_clean = 0; n_res = 0; clean_cyc = -1; res_cyc = -1; clean_val = -1;
        busy_ok = 1'b1; overlap = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 6 && !busy) busy_ok = 1'b0;
            if (clean_en && res_valid) overlap = 1'b1;
            if (clean_en) begin
                n_clean++; clean_cyc = c; clean_val = int'(clean);
            end
            if (res_valid) begin
                n_res++; res_cyc = c;
                r_node = min_node; r_idx = min_idx; r_empty = min_empty;
            end
            start = repulse && (c == 2 || c == 4);
            if (do_change && c == 3) nodes_in[NW-1:0] = new_u0;
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_clean_en", clean_en, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_min_node", min_node, 0);
        chk("rst_min_idx", min_idx, 0);
        chk("rst_min_empty", min_empty, 0);
        rstN = 1'b1;
        step();

        // Basic pick with an empty unit present
        nodes_in = {ONES, 36'h000090003, 36'h000020002, 36'h000050001};
        run_pick(1'b0, 1'b0, '0);
        chk("t1_n_clean", n_clean, 1);
        chk("t1_clean_cyc", clean_cyc, 5);
        chk("t1_clean", clean_val, 1);
        chk("t1_res_cyc", res_cyc, 6);
        chk("t1_n_res", n_res, 1);
        chk("t1_node", r_node, 36'h000020002);
        chk("t1_idx", r_idx, 1);
        chk("t1_empty", r_empty, 0);
        chk("t1_overlap", overlap, 0);
        chk("t1_busy", busy_ok, 1);
        repeat (3) step();
        chk("t1_hold_node", min_node, 36'h000020002);
        chk("t1_hold_idx", min_idx, 1);
        chk("t1_idle_busy", busy, 0);

        // All units empty
        nodes_in = '1;
        run_pick(1'b0, 1'b0, '0);
        chk("t2_n_clean", n_clean, 0);
        chk("t2_res_cyc", res_cyc, 6);
        chk("t2_empty", r_empty, 1);
        chk("t2_node", r_node, ONES);
        chk("t2_idx", r_idx, 0);

        // Tie between units 1 and 3
        nodes_in = {36'h000030000, 36'h000050000, 36'h000030000, 36'h000070000};
        run_pick(1'b0, 1'b0, '0);
        chk("t3_idx", r_idx, 1);
        chk("t3_clean", clean_val, 1);
        chk("t3_node", r_node, 36'h000030000);

        // Minimum in the last unit
        nodes_in = {36'h000000002, 36'h000000008, ONES, 36'h000000004};
        run_pick(1'b0, 1'b0, '0);
        chk("t4_idx", r_idx, 3);
        chk("t4_clean", clean_val, 3);
        chk("t4_node", r_node, 36'h000000002);
        chk("t4_clean_cyc", clean_cyc, 5);

        // start re-pulsed while busy
        nodes_in = {ONES, 36'h000090003, 36'h000020002, 36'h000050001};
        run_pick(1'b1, 1'b0, '0);
        chk("t5_n_clean", n_clean, 1);
        chk("t5_n_res", n_res, 1);
        chk("t5_busy", busy_ok, 1);
        chk("t5_res_cyc", res_cyc, 6);

        // Unit 0 lowered after it was scanned
        nodes_in = {36'h000000007, 36'h000000006, 36'h000000005, 36'h000000001};
        run_pick(1'b0, 1'b1, 36'h000000000);
        chk("t6_idx", r_idx, 0);
        chk("t6_node", r_node, 36'h000000001);

        // Reset in the middle of SCAN
        nodes_in = {ONES, 36'h000090003, 36'h000020002, 36'h000050001};
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("t7_busy_pre", busy, 1);
        rstN = 1'b0;
        #1;
        chk("t7_busy", busy, 0);
        chk("t7_clean_en", clean_en, 0);
        chk("t7_res_valid", res_valid, 0);
        chk("t7_min_node", min_node, 0);
        chk("t7_min_idx", min_idx, 0);
        @(negedge clk);
        rstN = 1'b1;
        n_clean = 0; n_res = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (clean_en) n_clean++;
            if (res_valid) n_res++;
        end
        chk("t7_no_clean", n_clean, 0);
        chk("t7_no_res", n_res, 0);
        run_pick(1'b0, 1'b0, '0);
        chk("t7_after_idx", r_idx, 1);
        chk("t7_after_res_cyc", res_cyc, 6);
        chk("t7_after_node", r_node, 36'h000020002);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/node_min_select.md
NODE_MIN_SELECT -- requirements
Module: node_min_select

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 16, meaning the number of node store units scanned (legal 2..256).
REQ-002 SHALL have parameter NODE_W, default 36, meaning the node frame width.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rstN  input  1  reset, asynchronous, active-low.
REQ-005 nodes_in  input  NODE_W*NUM_UNITS  concatenated node_out of every store unit; unit i occupies bits [NODE_W*i +: NODE_W].
REQ-006 start  input  1  request one minimum pick; sampled only in IDLE.
REQ-007 busy  output  1  high from the cycle after start is accepted until the return to IDLE.
REQ-008 clean  output  8  index of the store unit to invalidate.
REQ-009 clean_en  output  1  single-cycle strobe qualifying clean.
REQ-010 min_node  output  NODE_W  selected minimum node frame.
REQ-011 min_idx  output  8  index of the selected unit.
REQ-012 min_empty  output  1  high when no unit held a valid node.
REQ-013 res_valid  output  1  single-cycle strobe qualifying min_node, min_idx and min_empty.

Function
REQ-014 SHALL treat a node equal to all-ones (36'hF_FFFF_FFFF) as empty and every other value as valid.
REQ-015 SHALL order nodes by unsigned compare of the full NODE_W frame (weight in MSBs).
REQ-016 SHALL use an FSM with states IDLE, SCAN, CLEAN, DONE.
REQ-017 IDLE: start=1 -> SCAN with scan index 0, best = all-ones, found = 0; start=0 -> remain.
REQ-018 SCAN: one unit per cycle, index 0..NUM_UNITS-1 in ascending order; a valid unit replaces best only when strictly less than best.
REQ-019 Ties SHALL resolve to the lowest index.
REQ-020 SCAN: after index NUM_UNITS-1 is evaluated, the FSM SHALL go to CLEAN; the scan index SHALL NOT wrap.
REQ-021 CLEAN: if found=1, clean_en=1 and clean=best index for exactly that cycle; if found=0, clean_en stays 0.
REQ-022 DONE: res_valid=1 for one cycle with registered outputs min_node=best, min_idx=best index, min_empty=!found; next state IDLE.
REQ-023 Latency: start accepted at edge k -> clean_en high in cycle k+NUM_UNITS+1 -> res_valid high in cycle k+NUM_UNITS+2.
REQ-024 Any next start SHALL be accepted no earlier than the cycle after res_valid.
REQ-025 start while busy SHALL be ignored and SHALL NOT be queued.
REQ-026 nodes_in changes during SCAN SHALL be honoured only for units not yet scanned; already-scanned units SHALL NOT be re-evaluated.
REQ-027 min_empty=1 SHALL force min_node=all-ones and min_idx=0.
REQ-028 min_node, min_idx and min_empty SHALL hold their values until the next DONE.
REQ-029 clean_en and res_valid SHALL never be high in the same cycle.

Reset
REQ-030 rstN low SHALL asynchronously force state IDLE, busy=0, clean=0, clean_en=0, min_node=0, min_idx=0, min_empty=0, res_valid=0, scan index 0, found=0.
REQ-031 Reset mid-SCAN or mid-CLEAN SHALL abandon the pick with no clean_en or res_valid emitted.

Structure
REQ-032 NODE_W, the EMPTY_NODE constant (all-ones), and IDX_W=8 SHALL live in shared package huff_pkg, together with the node store units.
REQ-033 The compare (valid and strictly less) SHALL be one combinational sub-module, node_cmp, reused by the future pair-picker.
REQ-034 The implementation SHALL use no multi-cycle paths; the nodes_in mux SHALL be indexed by the registered scan index.

Verification (NUM_UNITS=4)
REQ-035 Nodes {0x000050001, 0x000020002, 0x000090003, all-ones}, start -> clean_en with clean=1 at k+5; res_valid at k+6 with min_node=0x000020002, min_idx=1, min_empty=0.
REQ-036 All four units all-ones, start -> no clean_en; res_valid at k+6 with min_empty=1, min_node=all-ones, min_idx=0.
REQ-037 Units 1 and 3 both 0x000030000, others larger -> min_idx=1 and clean=1.
REQ-038 start re-pulsed at k+2 and k+4 -> exactly one clean_en and one res_valid; busy stays continuously high from k+1 to k+6.
REQ-039 rstN pulsed low at k+3 during SCAN -> all outputs 0 immediately; no clean_en or res_valid afterwards; new start completes normally.
REQ-040 Unit 0 changed from 0x1 to 0x0 at k+3, after it has been scanned -> result still min_idx=0 with min_node=0x1 (snapshot rule).
